vga_fb_arbiter: RTL

Frame-buffer arbiter and scan-out sequencer for the 640x480 VGA path. Shares one single-port pixel RAM between display scan-out (absolute priority during the visible region) and a pixel writer (drawing engine/CPU), which is buffered in a small FIFO and drained during blanking. Sits between the sync generator (column/row/ready) and the colour outputs, replacing the direct pattern-generation control stage.

---
 rtl/vga_fb_arbiter_pkg.sv | 29 ++
 rtl/vga_fb_arbiter_if.sv | 13 +
 rtl/vga_fb_arbiter_fifo.sv | 64 ++++++
 rtl/vga_fb_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants, types and the display address helper for the VGA
// frame-buffer arbiter.
package vga_fb_arbiter_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int ADDR_W     = 19;
  localparam int PIX_W      = 3;
  localparam int COORD_W    = 11;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(H_ACTIVE * V_ACTIVE);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_DISP  = 3'b010,
    ST_DRAIN = 3'b100
  } arb_state_e;

  // row*640 + col built from two shifts (640 = 512 + 128), so no multiplier
  function automatic addr_t calcDispAddr(input logic [COORD_W-1:0] row,
                                         input logic [COORD_W-1:0] col);
    return (addr_t'(row) << 9) + (addr_t'(row) << 7) + addr_t'(col);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer handshake: a transfer happens on any cycle with req && rdy.
interface vga_fb_arbiter_if;
  import vga_fb_arbiter_pkg::*;

  logic   req;
  addr_t  addr;
  pixel_t data;
  logic   rdy;

  modport master (output req, addr, data, input rdy);
  modport slave  (input req, addr, data, output rdy);

endinterface

// File: rtl/vga_fb_arbiter_fifo.sv
// Small synchronous FIFO holding pending pixel writes (address + colour)
// until the arbiter finds a blanking cycle to drain them.
module vga_fb_arbiter_fifo
  import vga_fb_arbiter_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  addr_t  i_pushAddr,
  input  pixel_t i_pushData,
  input  logic   i_pop,
  output addr_t  o_headAddr,
  output pixel_t o_headData,
  output logic   o_full,
  output logic   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  addr_t            r_addrMem [DEPTH];
  pixel_t           r_dataMem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  assign o_headAddr = r_addrMem[r_rdPtr];
  assign o_headData = r_dataMem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_addrMem[r_wrPtr] <= i_pushAddr;
      r_dataMem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: scan-out owns the single-port pixel RAM during the
// visible area; buffered writer traffic drains into it during blanking.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ready,
  input  logic [COORD_W-1:0] i_columnAddr,
  input  logic [COORD_W-1:0] i_rowAddr,
  input  logic               i_hsync,
  input  logic               i_vsync,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_red,
  output logic               o_green,
  output logic               o_blue,
  vga_fb_arbiter_if.slave    wr,
  output addr_t              o_memAddr,
  output logic               o_memWrEn,
  output pixel_t             o_memWrData,
  input  pixel_t             i_memRdData,
  output logic               o_drop
);

  arb_state_e r_state;
  arb_state_e w_nextState;
  addr_t      w_dispAddr;
  addr_t      w_headAddr;
  pixel_t     w_headData;
  logic       w_fifoFull;
  logic       w_fifoEmpty;
  logic       w_pop;
  addr_t      r_memAddr;
  pixel_t     r_memWrData;
  logic       r_inRange;
  logic [1:0] r_readyDly;
  logic [2:0] r_hsDly;
  logic [2:0] r_vsDly;
  pixel_t     r_rgb;

  vga_fb_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (wr.req),
    .i_pushAddr (wr.addr),
    .i_pushData (wr.data),
    .i_pop      (w_pop),
    .o_headAddr (w_headAddr),
    .o_headData (w_headData),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty)
  );

  assign wr.rdy     = !w_fifoFull;
  assign w_dispAddr = i_ready ? calcDispAddr(i_rowAddr, i_columnAddr) : '0;
  assign w_pop      = (w_nextState == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Display always wins; the writer is starved for the whole visible line
  always_comb begin
    w_nextState = ST_IDLE;
    if (i_ready)           w_nextState = ST_DISP;
    else if (!w_fifoEmpty) w_nextState = ST_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memAddr   <= '0;
      r_memWrData <= '0;
      r_inRange   <= 1'b0;
    end else begin
      case (w_nextState)
        ST_DISP:  r_memAddr <= w_dispAddr;
        ST_DRAIN: begin
          r_memAddr   <= w_headAddr;
          r_memWrData <= w_headData;
          r_inRange   <= (w_headAddr < FB_WORDS);
        end
        default:  r_memAddr <= r_memAddr;
      endcase
    end
  end

  // Out-of-range entries are still popped, but turn into a drop pulse
  assign o_memAddr   = r_memAddr;
  assign o_memWrData = r_memWrData;
  assign o_memWrEn   = (r_state == ST_DRAIN) && r_inRange;
  assign o_drop      = (r_state == ST_DRAIN) && !r_inRange;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_readyDly <= '0;
      r_hsDly    <= '1;
      r_vsDly    <= '1;
      r_rgb      <= '0;
    end else begin
      r_readyDly <= {r_readyDly[0], i_ready};
      r_hsDly    <= {r_hsDly[1:0], i_hsync};
      r_vsDly    <= {r_vsDly[1:0], i_vsync};
      r_rgb      <= r_readyDly[1] ? i_memRdData : '0;
    end
  end

  assign o_hsync = r_hsDly[2];
  assign o_vsync = r_vsDly[2];
  assign o_red   = r_rgb[2];
  assign o_green = r_rgb[1];
  assign o_blue  = r_rgb[0];

endmodule
